ps2_menu_keys: RTL and testbench
================================

// Module: ps2_menu_keys
// PURPOSE
//  Receives PS/2 keyboard frames and turns scancodes into menu/game key events.
//  Drives up/down/start_trigger of the start menu as one-cycle pulses.
//  Drives held levels for paddle control.
//  Sits between the board PS/2 pins and start_menu / game logic; single clock domain clk_0.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  clk_0 cycles with no PS/2 falling edge mid-frame before the frame is aborted (2 ms @ 25 MHz)
//  KEY_UP          8'h75  E0-extended scancode for Up (arrow up)
//  KEY_DOWN        8'h72  E0-extended scancode for Down (arrow down)
//  KEY_START       8'h5A  non-extended scancode for Start (Enter)
// PORTS
//  clk_0          in   1  system clock
//  rst            in   1  synchronous reset, active-low
//  ps2_clk        in   1  raw PS/2 clock pin, asynchronous
//  ps2_data       in   1  raw PS/2 data pin, asynchronous
//  up             out  1  one-cycle pulse on Up make
//  down           out  1  one-cycle pulse on Down make
//  start_trigger  out  1  one-cycle pulse on Start make
//  up_held        out  1  level: Up currently pressed
//  down_held      out  1  level: Down currently pressed
//  frame_err      out  1  one-cycle pulse on a bad start, parity, stop or timeout
// BEHAVIOUR
//  - Sync: 2-FF synchronizer on ps2_clk and ps2_data; ps2_clk is idle-high.
//  - Sampling: data is sampled on the cycle a synced ps2_clk 1->0 transition is detected.
//  - Frame FSM states: IDLE, DATA, PARITY, STOP.
//    IDLE -> DATA when the sampled start bit is 0; a sampled 1 stays in IDLE with no error.
//    DATA: 8 bits, LSB first, 3-bit counter; -> PARITY after bit 7.
//    PARITY: bit must make the 9-bit sum odd.
//    STOP: bit must be 1; -> IDLE always.
//  - Byte valid: a one-cycle internal strobe in the cycle after stop-bit sampling, only if parity and stop are good.
//    Otherwise frame_err pulses in that same cycle and the byte is dropped.
//  - Timeout: in DATA, PARITY or STOP, a counter reloads on every falling edge.
//    Reaching TIMEOUT_CYCLES -> IDLE, frame_err pulses for 1 cycle.
//  - Decoder flags brk and ext.
//    Byte F0 sets brk; byte E0 sets ext; no output for either byte.
//    Any other byte: generate a key event using the current brk/ext, then clear both flags.
//    Any frame_err also clears both flags.
//  - Key mapping:
//    up key    = ext & byte==KEY_UP
//    down key  = ext & byte==KEY_DOWN
//    start key = !ext & byte==KEY_START
//    Unmapped bytes are ignored, but they still clear the flags.
//  - Make (brk=0):
//    pulse fires 1 cycle after the byte strobe (2 cycles after stop-bit sample), then the held level is set.
//    Typematic repeat rule: a make for a key whose held level is already 1 produces no pulse.
//    Start has an internal held flag for the same repeat suppression.
//  - Break (brk=1): clears that key's held level; no pulse.
//  - Simultaneous keys: up_held and down_held are independent; both may be 1.
//  - Reset (rst=0) at any time, including mid-frame:
//    FSM -> IDLE; counters, flags and synchronizers reset to idle (1);
//    all outputs 0 on the next edge.
// CONFIGURATION
//  PS2_WASD_EN defined:
//    non-extended 8'h1D (W) also maps to the up key;
//    non-extended 8'h1B (S) also maps to the down key.
//    Held and repeat rules are shared with the arrow keys: either source sets the level, and its break clears it.
//  PS2_WASD_EN undefined: only the arrow keys map; 1D and 1B are ignored.
// TESTING
//  1. Frame E0 then 75 -> exactly one up pulse; up_held=1; no other outputs.
//  2. Then E0 F0 75 -> up_held=0; no pulse.
//  3. Frame 5A sent three times (typematic) -> one start_trigger pulse only.
//     Then F0 5A, then 5A -> a second pulse.
//  4. Frame 72 with even parity -> frame_err for 1 cycle; no pulse.
//     The next good E0 72 -> down pulse.
//  5. Stop ps2_clk after 4 data bits for 50000 cycles -> frame_err.
//     A full E0 72 sent afterwards -> down pulse.
//  6. rst low mid-frame with up_held=1 -> all outputs 0; next full E0 75 -> up pulse.
//     With PS2_WASD_EN: 1D -> up pulse; without it: 1D -> nothing.

Source files
------------

// File: rtl/ps2_menu_keys.sv
// PS/2 keyboard receiver and scancode decoder producing start-menu pulses and paddle held levels.
// Build option: define PS2_WASD_EN to also map W (1D) and S (1B) onto the up/down keys.
module ps2_menu_keys #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  KEY_UP         = 8'h75,
    parameter logic [7:0]  KEY_DOWN       = 8'h72,
    parameter logic [7:0]  KEY_START      = 8'h5A
) (
    input  logic clk_0,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic up,
    output logic down,
    output logic start_trigger,
    output logic up_held,
    output logic down_held,
    output logic frame_err
);

    localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    BYTE_BRK = 8'hF0;
    localparam logic [7:0]    BYTE_EXT = 8'hE0;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e state_q, state_d;

    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;
    logic fall, timeout;

    logic          shift_en, par_en, stop_en;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic          frame_ok;

    logic [7:0] byte_q;
    logic       byte_valid_q;
    logic       frame_err_q;

    logic brk_q, ext_q;
    logic key_byte;
    logic up_key, down_key, start_key;

    logic up_q, down_q, start_q;
    logic up_held_q, down_held_q, start_held_q;

    // Synchronizers idle high so reset never produces a phantom falling edge.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall    = clk_prev_q & ~clk_s2_q;
    assign timeout = (state_q != StIdle) && !fall && (to_cnt_q == TO_LAST);

    // Frame FSM: state register
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM: next state
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StIdle;
        end else if (fall) begin
            unique case (state_q)
                StIdle:   if (!dat_s2_q) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Frame FSM: outputs
    always_comb begin
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        unique case (state_q)
            StIdle:   ;
            StData:   shift_en = fall;
            StParity: par_en   = fall;
            StStop:   stop_en  = fall;
            default:  ;
        endcase
    end

    assign frame_ok = (^{shift_q, par_q}) & dat_s2_q;

    always_ff @(posedge clk_0) begin
        if (!rst) begin
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_q   <= {dat_s2_q, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end else if (state_q == StIdle) begin
                bit_cnt_q <= 3'd0;
            end
            if (par_en) begin
                par_q <= dat_s2_q;
            end
            if (state_q == StIdle || fall) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_LAST) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (stop_en) begin
                byte_q <= shift_q;
            end
            byte_valid_q <= stop_en && frame_ok;
            frame_err_q  <= (stop_en && !frame_ok) || timeout;
        end
    end

    assign key_byte = byte_valid_q && (byte_q != BYTE_BRK) && (byte_q != BYTE_EXT);

    always_comb begin
        up_key    = key_byte && ext_q && (byte_q == KEY_UP);
        down_key  = key_byte && ext_q && (byte_q == KEY_DOWN);
        start_key = key_byte && !ext_q && (byte_q == KEY_START);
`ifdef PS2_WASD_EN
        up_key    = up_key || (key_byte && !ext_q && (byte_q == 8'h1D));
        down_key  = down_key || (key_byte && !ext_q && (byte_q == 8'h1B));
`endif
    end

    // Prefix flags live until the next non-prefix byte or any framing error.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
        end else if (frame_err_q || key_byte) begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
        end else if (byte_valid_q) begin
            if (byte_q == BYTE_BRK) brk_q <= 1'b1;
            if (byte_q == BYTE_EXT) ext_q <= 1'b1;
        end
    end

    // A make while already held is typematic repeat and yields no pulse.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            start_q      <= 1'b0;
            up_held_q    <= 1'b0;
            down_held_q  <= 1'b0;
            start_held_q <= 1'b0;
        end else begin
            up_q    <= up_key && !brk_q && !up_held_q;
            down_q  <= down_key && !brk_q && !down_held_q;
            start_q <= start_key && !brk_q && !start_held_q;
            if (up_key)    up_held_q    <= !brk_q;
            if (down_key)  down_held_q  <= !brk_q;
            if (start_key) start_held_q <= !brk_q;
        end
    end

    assign up            = up_q;
    assign down          = down_q;
    assign start_trigger = start_q;
    assign up_held       = up_held_q;
    assign down_held     = down_held_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ps2_menu_keys.sv
// Self-checking bench for ps2_menu_keys: frame-level key model scheduled per cycle, plus literal checks.
module tb_ps2_menu_keys;

    localparam int unsigned TO = 50000;

    logic clk_0 = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic up, down, start_trigger, up_held, down_held, frame_err;

    always #5 clk_0 = ~clk_0;

    ps2_menu_keys #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_0        (clk_0),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .up           (up),
        .down         (down),
        .start_trigger(start_trigger),
        .up_held      (up_held),
        .down_held    (down_held),
        .frame_err    (frame_err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_fall = 0;
    int n_up = 0, n_dn = 0, n_st = 0, n_err = 0;

    // Model: logical key state, prefix flags, and per-cycle scheduled output changes.
    bit m_brk, m_ext, m_up, m_dn, m_st;
    bit e_uh, e_dh;
    bit [3:0] pulse_sched[int];  // bit0 up, bit1 down, bit2 start, bit3 frame_err
    bit       uh_sched[int];
    bit       dh_sched[int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sched(input int k, input bit [3:0] m);
        if (pulse_sched.exists(k)) pulse_sched[k] = pulse_sched[k] | m;
        else pulse_sched[k] = m;
    endtask

    task automatic compare();
        bit [3:0] p;
        p = 4'h0;
        if (uh_sched.exists(cyc)) e_uh = uh_sched[cyc];
        if (dh_sched.exists(cyc)) e_dh = dh_sched[cyc];
        if (pulse_sched.exists(cyc)) p = pulse_sched[cyc];
        check("outputs{up,down,start,err,up_held,down_held}",
              {26'd0, up, down, start_trigger, frame_err, up_held, down_held},
              {26'd0, p[0], p[1], p[2], p[3], e_uh, e_dh});
        n_up  += int'(up === 1'b1);
        n_dn  += int'(down === 1'b1);
        n_st  += int'(start_trigger === 1'b1);
        n_err += int'(frame_err === 1'b1);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_0);
            cyc++;
            #1;
            compare();
        end
    endtask

    // Pin falls after cycle c: 2 sync stages + edge detect + byte register -> err at c+3, keys at c+4.
    task automatic model_frame(input logic [7:0] b, input bit par, input bit stop, input int c);
        bit kup, kdn, kst;
        if (!((^{b, par}) && stop)) begin
            sched(c + 3, 4'h8);
            m_brk = 0;
            m_ext = 0;
            return;
        end
        if (b == 8'hF0) begin
            m_brk = 1;
            return;
        end
        if (b == 8'hE0) begin
            m_ext = 1;
            return;
        end
        kup = m_ext && b == 8'h75;
        kdn = m_ext && b == 8'h72;
        kst = !m_ext && b == 8'h5A;
`ifdef PS2_WASD_EN
        kup = kup || (!m_ext && b == 8'h1D);
        kdn = kdn || (!m_ext && b == 8'h1B);
`endif
        if (kup) begin
            if (!m_brk && !m_up) sched(c + 4, 4'h1);
            m_up = !m_brk;
            uh_sched[c + 4] = m_up;
        end
        if (kdn) begin
            if (!m_brk && !m_dn) sched(c + 4, 4'h2);
            m_dn = !m_brk;
            dh_sched[c + 4] = m_dn;
        end
        if (kst) begin
            if (!m_brk && !m_st) sched(c + 4, 4'h4);
            m_st = !m_brk;
        end
        m_brk = 0;
        m_ext = 0;
    endtask

    task automatic model_reset(input int c);
        pulse_sched.delete();
        uh_sched.delete();
        dh_sched.delete();
        uh_sched[c + 1] = 0;
        dh_sched[c + 1] = 0;
        {m_brk, m_ext, m_up, m_dn, m_st} = '0;
    endtask

    task automatic ps2_fall(input bit d);
        tick(2);
        ps2_data = d;
        tick(2);
        ps2_clk = 1'b0;
        last_fall = cyc;
    endtask

    task automatic ps2_rise();
        tick(4);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        bit par;
        par = ~(^b) ^ bad_par;
        ps2_fall(1'b0);
        ps2_rise();
        for (int i = 0; i < 8; i++) begin
            ps2_fall(b[i]);
            ps2_rise();
        end
        ps2_fall(par);
        ps2_rise();
        ps2_fall(stop);
        model_frame(b, par, stop, last_fall);
        ps2_rise();
        ps2_data = 1'b1;
        tick(6);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    initial begin
        e_uh = 0;
        e_dh = 0;
        tick(5);
        rst = 1'b1;
        tick(5);
        check("reset_outputs", {up, down, start_trigger, up_held, down_held, frame_err}, 6'b0);

        // 1: up make
        send(8'hE0);
        send(8'h75);
        check("t1_up_pulses", n_up, 1);
        check("t1_up_held", up_held, 1'b1);
        check("t1_other_pulses", n_dn + n_st + n_err, 0);

        // 2: up break
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("t2_up_held", up_held, 1'b0);
        check("t2_up_pulses", n_up, 1);

        // 3: typematic start
        repeat (3) send(8'h5A);
        check("t3_start_once", n_st, 1);
        send(8'hF0);
        send(8'h5A);
        send(8'h5A);
        check("t3_start_twice", n_st, 2);

        // Start bit of 1 is ignored silently
        ps2_fall(1'b1);
        ps2_rise();
        ps2_data = 1'b1;
        tick(20);
        check("glitch_no_err", n_err, 0);

        // 4: parity error, then good down make
        send_frame(8'h72, 1'b1, 1'b1);
        check("t4_err", n_err, 1);
        check("t4_no_down", n_dn, 0);
        send(8'hE0);
        send(8'h72);
        check("t4_down", n_dn, 1);
        check("t4_down_held", down_held, 1'b1);

        // Bad stop bit
        send_frame(8'h33, 1'b0, 1'b0);
        check("stop_err", n_err, 2);
        send(8'hE0);
        send(8'hF0);
        send(8'h72);
        check("down_released", down_held, 1'b0);

        // 5: timeout after 4 data bits
        ps2_fall(1'b0);
        ps2_rise();
        for (int i = 0; i < 4; i++) begin
            ps2_fall(i[0]);
            ps2_rise();
        end
        ps2_data = 1'b1;
        sched(last_fall + TO + 3, 4'h8);
        m_brk = 0;
        m_ext = 0;
        tick(TO + 20);
        check("t5_timeout_err", n_err, 3);
        send(8'hE0);
        send(8'h72);
        check("t5_down", n_dn, 2);

        // 6: both held, then reset mid-frame
        send(8'hE0);
        send(8'h75);
        check("t6_up", n_up, 2);
        check("t6_both_held", {up_held, down_held}, 2'b11);
        ps2_fall(1'b0);
        ps2_rise();
        ps2_fall(1'b0);
        ps2_rise();
        ps2_fall(1'b0);
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        model_reset(cyc);
        tick(4);
        check("t6_reset_outputs", {up, down, start_trigger, up_held, down_held, frame_err}, 6'b0);
        rst = 1'b1;
        tick(4);
        send(8'hE0);
        send(8'h75);
        check("t6_up_after_reset", n_up, 3);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);

        send(8'h1D);
        send(8'h1B);
`ifdef PS2_WASD_EN
        check("wasd_w_up", n_up, 4);
        check("wasd_s_down", n_dn, 3);
`else
        check("wasd_w_ignored", n_up, 3);
        check("wasd_s_ignored", n_dn, 2);
`endif
        send(8'hF0);
        send(8'h1D);
        check("wasd_w_released", up_held, 1'b0);
        tick(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
